// File: rtl/key_matrix_ps2_if.sv
// Host-keyboard / CPU-side bundle for key_matrix_ps2.
// master: drives strobes, clock enable and column select, and reads rows.
// slave:  the matrix emulator.
interface key_matrix_ps2_if #(
   parameter int unsigned NUM_COLS = 8,
   parameter int unsigned NUM_ROWS = 8
);
   localparam int unsigned COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

   logic                clk_en;
   logic                key_strobe;
   logic                key_pressed;
   logic                key_extended;
   logic [7:0]          key_code;
   logic [COL_W-1:0]    col;
   logic [NUM_ROWS-1:0] row_bits;
   logic                key_any;
   logic                swrst;

   modport master (
      output clk_en, key_strobe, key_pressed, key_extended, key_code, col,
      input  row_bits, key_any, swrst
   );

   modport slave (
      input  clk_en, key_strobe, key_pressed, key_extended, key_code, col,
      output row_bits, key_any, swrst
   );
endinterface

// File: rtl/key_matrix_ps2.sv
// PS/2 make/break strobes -> emulated Oric key matrix (one bit per cell),
// column-selected active-low row readout, and F10 hold-qualified soft reset.
// Optional build macro STUCK_KEY_EN: force-release all keys after STUCK_TICKS
// clk_en ticks with no key_strobe (recovers from lost break codes).
module key_matrix_ps2 #(
   parameter int unsigned NUM_COLS    = 8,
   parameter int unsigned NUM_ROWS    = 8,
   parameter int unsigned RST_HOLD    = 4
`ifdef STUCK_KEY_EN
   ,
   parameter int unsigned STUCK_TICKS = 2**20
`endif
) (
   input logic              clk_24,
   input logic              reset,
   key_matrix_ps2_if.slave  bus
);
   localparam int unsigned COL_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
`ifdef STUCK_KEY_EN
   localparam int unsigned IDLE_W = $clog2(STUCK_TICKS + 1);
`endif

   logic [NUM_COLS-1:0][NUM_ROWS-1:0] cell_q, cell_d;
   logic [NUM_ROWS-1:0]               row_bits_q, row_bits_d;
   logic                              key_any_q, key_any_d;
   logic                              swrst_q, swrst_d;
   logic                              f10_q, f10_d;
   logic [HOLD_W-1:0]                 hold_q, hold_d;
`ifdef STUCK_KEY_EN
   logic [IDLE_W-1:0]                 idle_q, idle_d;
   logic                              expire;
`endif

   logic       lk_hit;
   logic [2:0] lk_col, lk_row;
   logic       is_f10;

   // Scan-code lookup: {extended, code} -> {hit, col, row} (Oric layout).
   always_comb begin
      lk_hit = 1'b1;
      {lk_col, lk_row} = 6'd0;
      case (bus.key_code)
         // Arrows and DEL match with or without the E0 prefix.
         8'h74: {lk_col, lk_row} = {3'd4, 3'd7};  // right
         8'h72: {lk_col, lk_row} = {3'd4, 3'd6};  // down
         8'h6B: {lk_col, lk_row} = {3'd4, 3'd5};  // left
         8'h75: {lk_col, lk_row} = {3'd4, 3'd3};  // up
         8'h71: {lk_col, lk_row} = {3'd5, 3'd5};  // del
         default: begin
            if (bus.key_extended) begin
               lk_hit = 1'b0;
            end else begin
               case (bus.key_code)
                  8'h26: {lk_col, lk_row} = {3'd0, 3'd7};  // 3
                  8'h22: {lk_col, lk_row} = {3'd0, 3'd6};  // X
                  8'h16: {lk_col, lk_row} = {3'd0, 3'd5};  // 1
                  8'h2A: {lk_col, lk_row} = {3'd0, 3'd3};  // V
                  8'h2E: {lk_col, lk_row} = {3'd0, 3'd2};  // 5
                  8'h31: {lk_col, lk_row} = {3'd0, 3'd1};  // N
                  8'h3D: {lk_col, lk_row} = {3'd0, 3'd0};  // 7
                  8'h23: {lk_col, lk_row} = {3'd1, 3'd7};  // D
                  8'h15: {lk_col, lk_row} = {3'd1, 3'd6};  // Q
                  8'h76: {lk_col, lk_row} = {3'd1, 3'd5};  // ESC
                  8'h2B: {lk_col, lk_row} = {3'd1, 3'd3};  // F
                  8'h2D: {lk_col, lk_row} = {3'd1, 3'd2};  // R
                  8'h2C: {lk_col, lk_row} = {3'd1, 3'd1};  // T
                  8'h3B: {lk_col, lk_row} = {3'd1, 3'd0};  // J
                  8'h21: {lk_col, lk_row} = {3'd2, 3'd7};  // C
                  8'h1E: {lk_col, lk_row} = {3'd2, 3'd6};  // 2
                  8'h1A: {lk_col, lk_row} = {3'd2, 3'd5};  // Z
                  8'h14: {lk_col, lk_row} = {3'd2, 3'd4};  // LCTRL
                  8'h25: {lk_col, lk_row} = {3'd2, 3'd3};  // 4
                  8'h32: {lk_col, lk_row} = {3'd2, 3'd2};  // B
                  8'h36: {lk_col, lk_row} = {3'd2, 3'd1};  // 6
                  8'h3A: {lk_col, lk_row} = {3'd2, 3'd0};  // M
                  8'h52: {lk_col, lk_row} = {3'd3, 3'd7};  // '
                  8'h5D: {lk_col, lk_row} = {3'd3, 3'd6};  // backslash
                  8'h4E: {lk_col, lk_row} = {3'd3, 3'd3};  // -
                  8'h4C: {lk_col, lk_row} = {3'd3, 3'd2};  // ;
                  8'h46: {lk_col, lk_row} = {3'd3, 3'd1};  // 9
                  8'h42: {lk_col, lk_row} = {3'd3, 3'd0};  // K
                  8'h12: {lk_col, lk_row} = {3'd4, 3'd4};  // LSHIFT
                  8'h49: {lk_col, lk_row} = {3'd4, 3'd2};  // .
                  8'h41: {lk_col, lk_row} = {3'd4, 3'd1};  // ,
                  8'h29: {lk_col, lk_row} = {3'd4, 3'd0};  // SPACE
                  8'h54: {lk_col, lk_row} = {3'd5, 3'd7};  // [
                  8'h5B: {lk_col, lk_row} = {3'd5, 3'd6};  // ]
                  8'h66: {lk_col, lk_row} = {3'd5, 3'd5};  // backspace -> DEL
                  8'h11: {lk_col, lk_row} = {3'd5, 3'd4};  // LALT -> FUNCT
                  8'h4D: {lk_col, lk_row} = {3'd5, 3'd3};  // P
                  8'h44: {lk_col, lk_row} = {3'd5, 3'd2};  // O
                  8'h43: {lk_col, lk_row} = {3'd5, 3'd1};  // I
                  8'h3C: {lk_col, lk_row} = {3'd5, 3'd0};  // U
                  8'h1D: {lk_col, lk_row} = {3'd6, 3'd7};  // W
                  8'h1B: {lk_col, lk_row} = {3'd6, 3'd6};  // S
                  8'h1C: {lk_col, lk_row} = {3'd6, 3'd5};  // A
                  8'h24: {lk_col, lk_row} = {3'd6, 3'd3};  // E
                  8'h34: {lk_col, lk_row} = {3'd6, 3'd2};  // G
                  8'h33: {lk_col, lk_row} = {3'd6, 3'd1};  // H
                  8'h35: {lk_col, lk_row} = {3'd6, 3'd0};  // Y
                  8'h55: {lk_col, lk_row} = {3'd7, 3'd7};  // =
                  8'h5A: {lk_col, lk_row} = {3'd7, 3'd5};  // RETURN
                  8'h59: {lk_col, lk_row} = {3'd7, 3'd4};  // RSHIFT
                  8'h4A: {lk_col, lk_row} = {3'd7, 3'd3};  // /
                  8'h45: {lk_col, lk_row} = {3'd7, 3'd2};  // 0
                  8'h4B: {lk_col, lk_row} = {3'd7, 3'd1};  // L
                  8'h3E: {lk_col, lk_row} = {3'd7, 3'd0};  // 8
                  default: lk_hit = 1'b0;
               endcase
            end
         end
      endcase
   end

   assign is_f10 = !bus.key_extended && (bus.key_code == 8'h09);

   // Key-state, F10 hold and idle-timer next state.
   always_comb begin
      cell_d = cell_q;
      f10_d  = f10_q;
      hold_d = hold_q;

      if (bus.clk_en && f10_q && (hold_q != HOLD_W'(RST_HOLD))) begin
         hold_d = hold_q + HOLD_W'(1);
      end

`ifdef STUCK_KEY_EN
      expire = bus.clk_en && (idle_q == IDLE_W'(STUCK_TICKS - 1));
      idle_d = idle_q;
      if (bus.key_strobe || expire) begin
         idle_d = '0;
      end else if (bus.clk_en) begin
         idle_d = idle_q + IDLE_W'(1);
      end
      // Expiry clears first so a coincident strobe lands on the cleared map.
      if (expire) begin
         cell_d = '0;
         f10_d  = 1'b0;
         hold_d = '0;
      end
`endif

      if (bus.key_strobe) begin
         if (is_f10) begin
            f10_d = bus.key_pressed;
            if (!bus.key_pressed) begin
               hold_d = '0;
            end
         end else if (lk_hit) begin
            for (int unsigned c = 0; c < NUM_COLS; c++) begin
               for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                  if ((32'(lk_col) == c) && (32'(lk_row) == r)) begin
                     cell_d[c][r] = bus.key_pressed;
                  end
               end
            end
         end
      end
   end

   // Output next state: row readout from pre-strobe cells, flags from new state.
   always_comb begin
      row_bits_d = row_bits_q;
      if (bus.clk_en) begin
         row_bits_d = '1;  // out-of-range column reads as no keys
         for (int unsigned c = 0; c < NUM_COLS; c++) begin
            if (bus.col == COL_W'(c)) begin
               row_bits_d = ~cell_q[c];
            end
         end
      end
      key_any_d = |cell_d;
      swrst_d   = f10_d && (hold_d == HOLD_W'(RST_HOLD));
   end

   // State registers.
   always_ff @(posedge clk_24 or posedge reset) begin
      if (reset) begin
         cell_q     <= '0;
         f10_q      <= 1'b0;
         hold_q     <= '0;
         row_bits_q <= '1;
         key_any_q  <= 1'b0;
         swrst_q    <= 1'b0;
`ifdef STUCK_KEY_EN
         idle_q     <= '0;
`endif
      end else begin
         cell_q     <= cell_d;
         f10_q      <= f10_d;
         hold_q     <= hold_d;
         row_bits_q <= row_bits_d;
         key_any_q  <= key_any_d;
         swrst_q    <= swrst_d;
`ifdef STUCK_KEY_EN
         idle_q     <= idle_d;
`endif
      end
   end

   assign bus.row_bits = row_bits_q;
   assign bus.key_any  = key_any_q;
   assign bus.swrst    = swrst_q;
endmodule

// File: tb/tb_key_matrix_ps2.sv
// Directed bench for key_matrix_ps2 (default 8x8, RST_HOLD = 4).
// With STUCK_KEY_EN defined, also exercises the idle force-release (STUCK_TICKS = 16).
module tb_key_matrix_ps2;
   logic clk_24 = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   key_matrix_ps2_if #(.NUM_COLS(8), .NUM_ROWS(8)) bus ();

   key_matrix_ps2 #(
      .NUM_COLS    (8),
      .NUM_ROWS    (8),
      .RST_HOLD    (4)
`ifdef STUCK_KEY_EN
      ,
      .STUCK_TICKS (16)
`endif
   ) dut (
      .clk_24 (clk_24),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 clk_24 = ~clk_24;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One-cycle strobe; returns at the negedge after the capturing posedge.
   task automatic strobe(input logic ext, input logic [7:0] code, input logic pressed);
      @(negedge clk_24);
      bus.key_extended = ext;
      bus.key_code     = code;
      bus.key_pressed  = pressed;
      bus.key_strobe   = 1'b1;
      @(negedge clk_24);
      bus.key_strobe   = 1'b0;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk_24);
   endtask

   initial begin
      reset            = 1'b1;
      bus.clk_en       = 1'b1;
      bus.key_strobe   = 1'b0;
      bus.key_pressed  = 1'b0;
      bus.key_extended = 1'b0;
      bus.key_code     = 8'h00;
      bus.col          = 3'd7;
      cycles(2);
      reset = 1'b0;
      cycles(2);

      // Reset state
      check("rst_row", bus.row_bits, 8'hFF);
      check("rst_any", bus.key_any, 1'b0);
      check("rst_swrst", bus.swrst, 1'b0);

      // L + RSHIFT on column 7; output lags strobe by one clk_en edge
      strobe(1'b0, 8'h4B, 1'b1);
      check("L_same_edge", bus.row_bits, 8'hFF);
      cycles(1);
      check("L_row", bus.row_bits, 8'hFD);
      strobe(1'b0, 8'h59, 1'b1);
      cycles(1);
      check("L_rshift_row", bus.row_bits, 8'hED);
      check("L_rshift_any", bus.key_any, 1'b1);
      strobe(1'b0, 8'h4B, 1'b1);  // typematic repeat
      cycles(1);
      check("typematic_row", bus.row_bits, 8'hED);
      strobe(1'b0, 8'h4B, 1'b0);
      cycles(1);
      check("break_L_row", bus.row_bits, 8'hEF);
      strobe(1'b0, 8'h59, 1'b0);
      cycles(1);
      check("break_rshift_row", bus.row_bits, 8'hFF);
      check("break_any", bus.key_any, 1'b0);
      strobe(1'b0, 8'h59, 1'b0);  // break of released key
      cycles(1);
      check("double_break_row", bus.row_bits, 8'hFF);

      // Arrows with and without E0; exact-match entries
      bus.col = 3'd4;
      strobe(1'b1, 8'h75, 1'b1);
      cycles(1);
      check("e0_up_row", bus.row_bits, 8'hF7);
      strobe(1'b1, 8'h75, 1'b0);
      cycles(1);
      check("e0_up_break", bus.row_bits, 8'hFF);
      strobe(1'b0, 8'h75, 1'b1);
      cycles(1);
      check("plain_up_row", bus.row_bits, 8'hF7);
      strobe(1'b0, 8'h1C, 1'b1);
      cycles(1);
      check("A_col4_row", bus.row_bits, 8'hF7);
      bus.col = 3'd6;
      cycles(1);
      check("A_col6_row", bus.row_bits, 8'hDF);
      strobe(1'b1, 8'h1C, 1'b0);  // E0-1C is unmapped: A stays down
      cycles(1);
      check("unmapped_ext_row", bus.row_bits, 8'hDF);
      strobe(1'b0, 8'h75, 1'b0);

      // clk_en = 0 freezes row_bits; key_any still tracks
      bus.clk_en = 1'b0;
      strobe(1'b0, 8'h1C, 1'b0);
      cycles(2);
      check("hold_row", bus.row_bits, 8'hDF);
      check("hold_any", bus.key_any, 1'b0);
      bus.clk_en = 1'b1;
      cycles(1);
      check("resume_row", bus.row_bits, 8'hFF);

      // F10 held 4 ticks -> swrst; does not touch matrix
      strobe(1'b0, 8'h09, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycles(1);
         check("f10_pre", bus.swrst, 1'b0);
      end
      cycles(1);
      check("f10_rise", bus.swrst, 1'b1);
      check("f10_no_cell", bus.key_any, 1'b0);
      cycles(3);
      check("f10_stay", bus.swrst, 1'b1);
      strobe(1'b0, 8'h09, 1'b0);
      check("f10_drop", bus.swrst, 1'b0);

      // F10 released after 3 ticks: never asserts
      strobe(1'b0, 8'h09, 1'b1);
      cycles(2);
      strobe(1'b0, 8'h09, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("f10_short", bus.swrst, 1'b0);
         cycles(1);
      end

      // Reset mid-keypress / mid-hold
      bus.col = 3'd2;
      strobe(1'b0, 8'h21, 1'b1);
      strobe(1'b0, 8'h09, 1'b1);
      check("C_row", bus.row_bits, 8'h7F);
      cycles(1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_row", bus.row_bits, 8'hFF);
      check("async_rst_any", bus.key_any, 1'b0);
      check("async_rst_swrst", bus.swrst, 1'b0);
      @(negedge clk_24);
      reset = 1'b0;
      cycles(6);
      check("post_rst_row", bus.row_bits, 8'hFF);
      check("post_rst_swrst", bus.swrst, 1'b0);

`ifdef STUCK_KEY_EN
      // Idle expiry after 16 ticks without strobes
      reset = 1'b1;
      bus.col = 3'd6;
      cycles(1);
      reset = 1'b0;
      strobe(1'b0, 8'h1D, 1'b1);
      for (int i = 0; i < 16; i++) begin
         cycles(1);
         check("stuck_held_row", bus.row_bits, 8'h7F);
      end
      cycles(1);
      check("stuck_clear_row", bus.row_bits, 8'hFF);
      check("stuck_clear_any", bus.key_any, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
